// File: rtl/checkpoint_ctrl.sv
// Rename-table checkpoint sequencer: allocates labels per branch, retires them in
// age order, and turns mispredicts/exceptions into single recovery pulses.
module checkpoint_ctrl #(
    parameter int unsigned NUM_CHECKPOINTS = 4,
    localparam int unsigned PTR_W = $clog2(NUM_CHECKPOINTS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             branch_valid_i,
    output logic             branch_ready_o,
    output logic             do_checkpoint_o,
    output logic [PTR_W-1:0] alloc_id_o,
    input  logic             resolve_valid_i,
    input  logic [PTR_W-1:0] resolve_id_i,
    input  logic             resolve_mispredict_i,
    input  logic             exception_i,
    output logic             do_recover_o,
    output logic [PTR_W-1:0] recover_checkpoint_o,
    output logic             delete_checkpoint_o,
    output logic             recover_commit_o,
    output logic             flush_frontend_o,
    output logic [PTR_W:0]   num_used_o,
    output logic             out_of_checkpoints_o
);

    localparam int unsigned CW = PTR_W + 1;
    localparam logic [CW-1:0] MAX_USED = CW'(NUM_CHECKPOINTS - 1);

    typedef enum logic [1:0] {
        RUN,
        RECOVER,
        RECOVER_COMMIT,
        BUBBLE
    } state_e;

    state_e                     state_q, state_d;
    logic [PTR_W-1:0]           head_q, head_d;
    logic [PTR_W-1:0]           tail_q, tail_d;
    logic [CW-1:0]              count_q, count_d;
    logic [NUM_CHECKPOINTS-1:0] valid_q, valid_d;
    logic [NUM_CHECKPOINTS-1:0] ok_q, ok_d;
    logic [PTR_W-1:0]           rec_id_q, rec_id_d;

    logic                       mispredict;
    logic                       resolve_ok;
    logic                       alloc;
    logic                       delete;
    logic [PTR_W-1:0]           rollback_len;
    logic [PTR_W-1:0]           kept_len;
    logic [NUM_CHECKPOINTS-1:0] kill;

    assign mispredict = resolve_valid_i & resolve_mispredict_i & valid_q[resolve_id_i];
    assign resolve_ok = resolve_valid_i & ~resolve_mispredict_i & valid_q[resolve_id_i];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d              = state_q;
        do_recover_o         = (state_q == RECOVER);
        recover_commit_o     = (state_q == RECOVER_COMMIT);
        flush_frontend_o     = do_recover_o | recover_commit_o;
        recover_checkpoint_o = do_recover_o ? rec_id_q : '0;
        branch_ready_o       = (state_q == RUN) & (count_q < MAX_USED) & ~exception_i & ~mispredict;
        alloc                = branch_valid_i & branch_ready_o;
        do_checkpoint_o      = alloc;
        alloc_id_o           = head_q;
        delete               = valid_q[tail_q] & ok_q[tail_q] & ~do_recover_o
                               & ~recover_commit_o & ~exception_i;
        delete_checkpoint_o  = delete;
        num_used_o           = count_q;
        out_of_checkpoints_o = (count_q == MAX_USED);

        if (exception_i) begin
            state_d = RECOVER_COMMIT;
        end else if (mispredict) begin
            state_d = RECOVER;
        end else begin
            case (state_q)
                RECOVER, RECOVER_COMMIT: state_d = BUBBLE;
                BUBBLE:                  state_d = RUN;
                default:                 state_d = RUN;
            endcase
        end
    end

    // Entries from the mispredicted label up to head-1 (circular) are younger and die.
    assign rollback_len = head_q - resolve_id_i;
    assign kept_len     = resolve_id_i - tail_q;

    always_comb begin
        kill = '0;
        for (int unsigned i = 0; i < NUM_CHECKPOINTS; i++) begin
            kill[i] = ((PTR_W'(i) - resolve_id_i) < rollback_len);
        end
    end

    always_comb begin
        valid_d  = valid_q;
        ok_d     = ok_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        rec_id_d = rec_id_q;

        if (exception_i) begin
            valid_d = '0;
            ok_d    = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (delete) begin
                valid_d[tail_q] = 1'b0;
                ok_d[tail_q]    = 1'b0;
                tail_d          = tail_q + 1'b1;
            end
            if (mispredict) begin
                valid_d  = valid_d & ~kill;
                ok_d     = ok_d & ~kill;
                head_d   = resolve_id_i;
                count_d  = CW'(kept_len) - CW'(delete);
                rec_id_d = resolve_id_i;
            end else begin
                if (resolve_ok) begin
                    ok_d[resolve_id_i] = 1'b1;
                end
                if (alloc) begin
                    valid_d[head_q] = 1'b1;
                    ok_d[head_q]    = 1'b0;
                    head_d          = head_q + 1'b1;
                end
                count_d = count_q + CW'(alloc) - CW'(delete);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q  <= '0;
            ok_q     <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            rec_id_q <= '0;
        end else begin
            valid_q  <= valid_d;
            ok_q     <= ok_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            rec_id_q <= rec_id_d;
        end
    end

endmodule
